// File: rtl/jump_control_stack.sv
// Jump/branch/call/return decode with a DEPTH-entry return stack of {address, flags, int-frame}.
// Redirect outputs are combinational in the decode cycle; stack, sp, int_en and errors update on the clock.
module jump_control_stack #(
    parameter int                ADDR_W     = 8,
    parameter int                FLAG_W     = 4,
    parameter int                INS_W      = 20,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] INT_VECTOR = 8'hF0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [INS_W-1:0]             ins,
    input  logic                         ins_valid,
    input  logic [ADDR_W-1:0]            current_address,
    input  logic [FLAG_W-1:0]            flag_ex,
    input  logic                         irq,
    output logic                         pc_mux_sel,
    output logic [ADDR_W-1:0]            jmp_loc,
    output logic                         int_ack,
    output logic                         flag_restore_valid,
    output logic [FLAG_W-1:0]            flag_restore,
    output logic                         int_en,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         stack_overflow,
    output logic                         stack_underflow
);

    localparam int SP_W  = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

    localparam logic [4:0] OP_JMP  = 5'b11000;
    localparam logic [4:0] OP_CALL = 5'b11001;
    localparam logic [4:0] OP_JC   = 5'b11100;
    localparam logic [4:0] OP_JNC  = 5'b11101;
    localparam logic [4:0] OP_JZ   = 5'b11110;
    localparam logic [4:0] OP_JNZ  = 5'b11111;
    localparam logic [4:0] OP_RET  = 5'b10000;
    localparam logic [4:0] OP_RETI = 5'b10001;
    localparam logic [4:0] OP_EI   = 5'b10010;
    localparam logic [4:0] OP_DI   = 5'b10011;

    logic [4:0]        opcode;
    logic [ADDR_W-1:0] target;
    logic              unused_ins;

    assign opcode     = ins[INS_W-1 -: 5];
    assign target     = ins[ADDR_W-1:0];
    assign unused_ins = ^ins[INS_W-6:ADDR_W];

    logic [ADDR_W-1:0] stk_addr [DEPTH];
    logic [FLAG_W-1:0] stk_flag [DEPTH];
    logic              stk_int  [DEPTH];

    logic              stack_full;
    logic              stack_empty;
    logic              take_int;
    logic [SP_W-1:0]   sp_m1;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;
    logic [ADDR_W-1:0] top_addr;
    logic [FLAG_W-1:0] top_flag;
    logic              unused_top_int;

    assign stack_full  = (sp == SP_FULL);
    assign stack_empty = (sp == '0);
    assign sp_m1       = sp - SP_W'(1);
    assign wr_idx      = sp[IDX_W-1:0];
    assign top_idx     = sp_m1[IDX_W-1:0];
    assign top_addr    = stk_addr[top_idx];
    assign top_flag    = stk_flag[top_idx];
    // Frame type is stored for debug visibility only; RET/RETI never check it.
    assign unused_top_int = stk_int[top_idx];

    // Interrupt beats any instruction in the same slot; a full stack holds it off silently.
    assign take_int = ins_valid & irq & int_en & ~stack_full;

    logic              do_push;
    logic              do_pop;
    logic [ADDR_W-1:0] push_addr;
    logic              push_int;
    logic              set_int_en;
    logic              clr_int_en;
    logic              set_ovf;
    logic              set_unf;

    always_comb begin
        pc_mux_sel         = 1'b0;
        jmp_loc            = '0;
        int_ack            = 1'b0;
        flag_restore_valid = 1'b0;
        flag_restore       = '0;
        do_push            = 1'b0;
        do_pop             = 1'b0;
        push_addr          = '0;
        push_int           = 1'b0;
        set_int_en         = 1'b0;
        clr_int_en         = 1'b0;
        set_ovf            = 1'b0;
        set_unf            = 1'b0;

        if (ins_valid) begin
            if (take_int) begin
                pc_mux_sel = 1'b1;
                jmp_loc    = INT_VECTOR;
                int_ack    = 1'b1;
                do_push    = 1'b1;
                push_addr  = current_address;
                push_int   = 1'b1;
                clr_int_en = 1'b1;
            end else begin
                case (opcode)
                    OP_JMP: begin
                        pc_mux_sel = 1'b1;
                        jmp_loc    = target;
                    end
                    OP_CALL: begin
                        if (stack_full) begin
                            set_ovf = 1'b1;
                        end else begin
                            pc_mux_sel = 1'b1;
                            jmp_loc    = target;
                            do_push    = 1'b1;
                            push_addr  = current_address + ADDR_W'(1);
                        end
                    end
                    OP_JC: begin
                        pc_mux_sel = flag_ex[0];
                        jmp_loc    = flag_ex[0] ? target : '0;
                    end
                    OP_JNC: begin
                        pc_mux_sel = ~flag_ex[0];
                        jmp_loc    = flag_ex[0] ? '0 : target;
                    end
                    OP_JZ: begin
                        pc_mux_sel = flag_ex[1];
                        jmp_loc    = flag_ex[1] ? target : '0;
                    end
                    OP_JNZ: begin
                        pc_mux_sel = ~flag_ex[1];
                        jmp_loc    = flag_ex[1] ? '0 : target;
                    end
                    OP_RET: begin
                        if (stack_empty) begin
                            set_unf = 1'b1;
                        end else begin
                            pc_mux_sel = 1'b1;
                            jmp_loc    = top_addr;
                            do_pop     = 1'b1;
                        end
                    end
                    OP_RETI: begin
                        if (stack_empty) begin
                            set_unf = 1'b1;
                        end else begin
                            pc_mux_sel         = 1'b1;
                            jmp_loc            = top_addr;
                            flag_restore_valid = 1'b1;
                            flag_restore       = top_flag;
                            do_pop             = 1'b1;
                            set_int_en         = 1'b1;
                        end
                    end
                    OP_EI:   set_int_en = 1'b1;
                    OP_DI:   clr_int_en = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp              <= '0;
            int_en          <= 1'b0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            if (do_push)
                sp <= sp + SP_W'(1);
            else if (do_pop)
                sp <= sp_m1;

            if (set_int_en)
                int_en <= 1'b1;
            else if (clr_int_en)
                int_en <= 1'b0;

            if (set_ovf)
                stack_overflow <= 1'b1;
            if (set_unf)
                stack_underflow <= 1'b1;
        end
    end

    // Frame storage needs no reset: sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            stk_addr[wr_idx] <= push_addr;
            stk_flag[wr_idx] <= flag_ex;
            stk_int[wr_idx]  <= push_int;
        end
    end

endmodule

// File: tb/tb_jump_control_stack.sv
// Directed bench for jump_control_stack: hand-computed redirect, stack and interrupt expectations.
module tb_jump_control_stack;

    localparam logic [4:0] NOP  = 5'b00000;
    localparam logic [4:0] JMP  = 5'b11000;
    localparam logic [4:0] CALL = 5'b11001;
    localparam logic [4:0] JC   = 5'b11100;
    localparam logic [4:0] JNC  = 5'b11101;
    localparam logic [4:0] JZ   = 5'b11110;
    localparam logic [4:0] JNZ  = 5'b11111;
    localparam logic [4:0] RET  = 5'b10000;
    localparam logic [4:0] RETI = 5'b10001;
    localparam logic [4:0] EI   = 5'b10010;
    localparam logic [4:0] DI   = 5'b10011;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] ins;
    logic        ins_valid;
    logic [7:0]  current_address;
    logic [3:0]  flag_ex;
    logic        irq;
    logic        pc_mux_sel;
    logic [7:0]  jmp_loc;
    logic        int_ack;
    logic        flag_restore_valid;
    logic [3:0]  flag_restore;
    logic        int_en;
    logic [2:0]  sp;
    logic        stack_overflow;
    logic        stack_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    jump_control_stack dut (
        .clk                (clk),
        .reset              (reset),
        .ins                (ins),
        .ins_valid          (ins_valid),
        .current_address    (current_address),
        .flag_ex            (flag_ex),
        .irq                (irq),
        .pc_mux_sel         (pc_mux_sel),
        .jmp_loc            (jmp_loc),
        .int_ack            (int_ack),
        .flag_restore_valid (flag_restore_valid),
        .flag_restore       (flag_restore),
        .int_en             (int_en),
        .sp                 (sp),
        .stack_overflow     (stack_overflow),
        .stack_underflow    (stack_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Applies inputs shortly after a rising edge and lets the combinational outputs settle.
    task automatic drive(input logic v, input logic [4:0] op, input logic [7:0] tgt,
                         input logic [7:0] addr, input logic [3:0] fl, input logic rq);
        ins_valid       = v;
        ins             = {op, 7'b0, tgt};
        current_address = addr;
        flag_ex         = fl;
        irq             = rq;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, NOP, 8'h00, 8'h00, 4'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        chk("rst_sp", sp, 0);
        chk("rst_int_en", int_en, 0);
        chk("rst_ovf", stack_overflow, 0);
        chk("rst_unf", stack_underflow, 0);
        chk("rst_sel", pc_mux_sel, 0);

        // Unconditional jump, then same instruction as a bubble
        drive(1'b1, JMP, 8'h3C, 8'h05, 4'h0, 1'b0);
        chk("jmp_sel", pc_mux_sel, 1);
        chk("jmp_loc", jmp_loc, 8'h3C);
        tick();
        chk("jmp_sp", sp, 0);
        drive(1'b0, JMP, 8'h3C, 8'h05, 4'h0, 1'b0);
        chk("bubble_sel", pc_mux_sel, 0);
        chk("bubble_loc", jmp_loc, 8'h00);
        tick();

        // Conditional jumps on carry, then zero
        drive(1'b1, JC, 8'h10, 8'h06, 4'b0001, 1'b0);
        chk("jc_c1_sel", pc_mux_sel, 1);
        chk("jc_c1_loc", jmp_loc, 8'h10);
        drive(1'b1, JNC, 8'h10, 8'h06, 4'b0001, 1'b0);
        chk("jnc_c1_sel", pc_mux_sel, 0);
        drive(1'b1, JZ, 8'h10, 8'h06, 4'b0010, 1'b0);
        chk("jz_z1_sel", pc_mux_sel, 1);
        chk("jz_z1_loc", jmp_loc, 8'h10);
        drive(1'b1, JNZ, 8'h10, 8'h06, 4'b0010, 1'b0);
        chk("jnz_z1_sel", pc_mux_sel, 0);
        drive(1'b1, JC, 8'h10, 8'h06, 4'b0010, 1'b0);
        chk("jc_c0_sel", pc_mux_sel, 0);
        drive(1'b1, JNC, 8'h10, 8'h06, 4'b0010, 1'b0);
        chk("jnc_c0_sel", pc_mux_sel, 1);
        tick();

        // CALL at FF wraps the return address to 00; second RET underflows
        drive(1'b1, CALL, 8'h40, 8'hFF, 4'h0, 1'b0);
        chk("call_sel", pc_mux_sel, 1);
        chk("call_loc", jmp_loc, 8'h40);
        tick();
        chk("call_sp", sp, 1);
        drive(1'b1, RET, 8'h00, 8'h40, 4'h0, 1'b0);
        chk("ret_sel", pc_mux_sel, 1);
        chk("ret_loc", jmp_loc, 8'h00);
        chk("ret_frv", flag_restore_valid, 0);
        tick();
        chk("ret_sp", sp, 0);
        chk("ret_unf_clear", stack_underflow, 0);
        drive(1'b1, RET, 8'h00, 8'h41, 4'h0, 1'b0);
        chk("ret_empty_sel", pc_mux_sel, 0);
        tick();
        chk("ret_empty_unf", stack_underflow, 1);
        chk("ret_empty_sp", sp, 0);

        // EI, interrupt over a JMP, RETI restores flags and int_en
        drive(1'b1, EI, 8'h00, 8'h20, 4'h0, 1'b0);
        tick();
        chk("ei_int_en", int_en, 1);
        drive(1'b1, JMP, 8'h55, 8'h22, 4'hA, 1'b1);
        chk("irq_ack", int_ack, 1);
        chk("irq_loc", jmp_loc, 8'hF0);
        chk("irq_sel", pc_mux_sel, 1);
        tick();
        chk("irq_int_en", int_en, 0);
        chk("irq_sp", sp, 1);
        drive(1'b1, NOP, 8'h00, 8'hF0, 4'h0, 1'b1);
        chk("irq_masked_ack", int_ack, 0);
        tick();
        drive(1'b1, RETI, 8'h00, 8'hF1, 4'h3, 1'b0);
        chk("reti_loc", jmp_loc, 8'h22);
        chk("reti_frv", flag_restore_valid, 1);
        chk("reti_flags", flag_restore, 4'hA);
        tick();
        chk("reti_int_en", int_en, 1);
        chk("reti_sp", sp, 0);

        // DI, then EI with irq in the same cycle: taken only next cycle
        drive(1'b1, DI, 8'h00, 8'h23, 4'h0, 1'b0);
        tick();
        chk("di_int_en", int_en, 0);
        drive(1'b1, EI, 8'h00, 8'h24, 4'h0, 1'b1);
        chk("ei_same_ack", int_ack, 0);
        tick();
        drive(1'b0, NOP, 8'h00, 8'h25, 4'h0, 1'b1);
        chk("bubble_irq_ack", int_ack, 0);
        tick();
        chk("bubble_irq_sp", sp, 0);
        drive(1'b1, NOP, 8'h00, 8'h25, 4'h6, 1'b1);
        chk("ei_next_ack", int_ack, 1);
        tick();
        drive(1'b1, RETI, 8'h00, 8'hF0, 4'h0, 1'b0);
        chk("reti2_loc", jmp_loc, 8'h25);
        chk("reti2_flags", flag_restore, 4'h6);
        tick();
        chk("reti2_sp", sp, 0);

        // Fill the stack: three CALLs plus an interrupt frame
        drive(1'b1, CALL, 8'h50, 8'h10, 4'h0, 1'b0);
        tick();
        drive(1'b1, CALL, 8'h60, 8'h20, 4'h0, 1'b0);
        tick();
        drive(1'b1, CALL, 8'h70, 8'h30, 4'h0, 1'b0);
        tick();
        chk("fill_sp3", sp, 3);
        drive(1'b1, EI, 8'h00, 8'h43, 4'h0, 1'b0);
        tick();
        drive(1'b1, NOP, 8'h00, 8'h44, 4'h5, 1'b1);
        chk("fill_irq_ack", int_ack, 1);
        tick();
        chk("fill_sp4", sp, 4);
        drive(1'b1, CALL, 8'h80, 8'h45, 4'h0, 1'b0);
        chk("ovf_sel", pc_mux_sel, 0);
        tick();
        chk("ovf_flag", stack_overflow, 1);
        chk("ovf_sp", sp, 4);
        drive(1'b1, EI, 8'h00, 8'h46, 4'h0, 1'b0);
        tick();
        drive(1'b1, NOP, 8'h00, 8'h46, 4'h0, 1'b1);
        chk("full_irq_ack", int_ack, 0);
        tick();
        chk("full_irq_sp", sp, 4);
        chk("full_no_unf_change", stack_overflow, 1);
        // RET on an interrupt frame pops it without flag restore
        drive(1'b1, RET, 8'h00, 8'h47, 4'h0, 1'b1);
        chk("full_ret_ack", int_ack, 0);
        chk("full_ret_loc", jmp_loc, 8'h44);
        chk("full_ret_frv", flag_restore_valid, 0);
        tick();
        chk("full_ret_sp", sp, 3);
        drive(1'b1, NOP, 8'h00, 8'h44, 4'h7, 1'b1);
        chk("held_irq_ack", int_ack, 1);
        tick();
        chk("held_irq_sp", sp, 4);
        drive(1'b1, RETI, 8'h00, 8'hF0, 4'h0, 1'b0);
        chk("unwind_reti_loc", jmp_loc, 8'h44);
        chk("unwind_reti_flags", flag_restore, 4'h7);
        tick();
        drive(1'b1, RET, 8'h00, 8'h70, 4'h0, 1'b0);
        chk("unwind_ret3_loc", jmp_loc, 8'h31);
        tick();
        drive(1'b1, RET, 8'h00, 8'h60, 4'h0, 1'b0);
        chk("unwind_ret2_loc", jmp_loc, 8'h21);
        tick();
        drive(1'b1, RET, 8'h00, 8'h50, 4'h0, 1'b0);
        chk("unwind_ret1_loc", jmp_loc, 8'h11);
        tick();
        chk("unwind_sp", sp, 0);
        chk("unwind_int_en", int_en, 1);

        // Reset beats a CALL at sp=2 and clears sticky errors
        drive(1'b1, CALL, 8'h90, 8'h01, 4'h0, 1'b0);
        tick();
        drive(1'b1, CALL, 8'h91, 8'h02, 4'h0, 1'b0);
        tick();
        chk("pre_rst_sp", sp, 2);
        drive(1'b1, CALL, 8'h92, 8'h03, 4'h0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_sp", sp, 0);
        chk("mid_rst_int_en", int_en, 0);
        chk("mid_rst_ovf", stack_overflow, 0);
        chk("mid_rst_unf", stack_underflow, 0);
        drive(1'b1, RET, 8'h00, 8'h04, 4'h0, 1'b0);
        chk("post_rst_ret_sel", pc_mux_sel, 0);
        tick();
        chk("post_rst_unf", stack_underflow, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
